// File: rtl/pipe_hazard_ctrl_if.sv
// ID-side bundle between the decode stage and pipe_hazard_ctrl: ID instruction tags,
// branch/memory status in, freeze/hazard/flush and counters out.
// Handshake: mem_ready acts as the ready of the data-memory stage. A cycle with mem_ready=0
// completes nothing and every pipeline register holds. No transfer has a valid without its ready.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_two_src;
  logic                  id_wb_en;
  logic                  id_mem_read;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  branch_taken;
  logic                  mem_ready;
  logic                  freeze;
  logic                  hazard;
  logic                  flush;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_read, id_dest,
           branch_taken, mem_ready,
    input  freeze, hazard, flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_read, id_dest,
           branch_taken, mem_ready,
    output freeze, hazard, flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flush/freeze control: DEPTH-entry writeback scoreboard, RAW interlock,
// branch flush sequencing and memory-wait freeze. Define FORWARDING_EN to stall on load-use only.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W   = 4,
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] dest;
  } sb_entry_t;

  localparam int REM_W = 3;
  localparam logic [REM_W-1:0] REM_RELOAD = REM_W'(FLUSH_CYCLES - 1);

  sb_entry_t        sb_q [DEPTH];
  sb_entry_t        sb_d [DEPTH];
  logic [REM_W-1:0] flush_rem_q, flush_rem_d;
  logic             branch_pending_q, branch_pending_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_wait;
  logic flush_start;
  logic flush;
  logic raw;
  logic hazard;
  logic match1;
  logic match2;
  logic live;

  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    live   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      live = sb_q[i].valid & sb_q[i].wb_en;
`ifdef FORWARDING_EN
      // Everything but a load still in EXE can be forwarded.
      live = live & sb_q[i].mem_read & (i == 0);
`endif
      if (live && (sb_q[i].dest == bus.id_src1)) match1 = 1'b1;
      if (live && (sb_q[i].dest == bus.id_src2)) match2 = 1'b1;
    end
    raw = bus.id_valid & (match1 | (bus.id_two_src & match2));
  end

  assign mem_wait    = ~bus.mem_ready;
  assign flush_start = (bus.branch_taken | branch_pending_q) & ~mem_wait;
  assign flush       = ~mem_wait & (flush_start | (flush_rem_q != '0));
  // The ID instruction is discarded by a flush, so it cannot also stall.
  assign hazard      = raw & ~flush;

  always_comb begin
    sb_d             = sb_q;
    flush_rem_d      = flush_rem_q;
    branch_pending_d = branch_pending_q;
    stall_cnt_d      = stall_cnt_q;
    flush_cnt_d      = flush_cnt_q;
    if (mem_wait) begin
      branch_pending_d = branch_pending_q | bus.branch_taken;
    end else begin
      for (int i = 1; i < DEPTH; i++) sb_d[i] = sb_q[i-1];
      sb_d[0] = '0;
      if (bus.id_valid && !hazard && !flush) begin
        sb_d[0] = '{valid: 1'b1, wb_en: bus.id_wb_en, mem_read: bus.id_mem_read, dest: bus.id_dest};
      end
      if (flush_start) begin
        flush_rem_d      = REM_RELOAD;
        branch_pending_d = 1'b0;
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (flush_rem_q != '0) begin
        flush_rem_d = flush_rem_q - REM_W'(1);
      end
      if (hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= '0;
      flush_rem_q      <= '0;
      branch_pending_q <= 1'b0;
      stall_cnt_q      <= '0;
      flush_cnt_q      <= '0;
    end else begin
      sb_q             <= sb_d;
      flush_rem_q      <= flush_rem_d;
      branch_pending_q <= branch_pending_d;
      stall_cnt_q      <= stall_cnt_d;
      flush_cnt_q      <= flush_cnt_d;
    end
  end

  assign bus.freeze    = hazard | mem_wait;
  assign bus.hazard    = hazard;
  assign bus.flush     = flush;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline control unit that replaces the constant freeze/hazard/flush tie-offs of the 5-stage ARM core. It keeps a DEPTH-entry scoreboard of instructions in flight after ID (EXE, MEM, WB by default) and detects RAW hazards against the instruction in ID. It also sequences flushes on taken branches and freezes the pipe while data memory is not ready. Sits beside ID_stage; its outputs drive the IF/ID register freeze/flush and the ID hazard input.

Parameters:
REG_ADDR_W, 4, register-file address width (dest/src tag width)
DEPTH, 3, scoreboard entries (stages after ID that can still write back); legal 1..8
FLUSH_CYCLES, 1, cycles flush stays high per taken branch; legal 1..4
CNT_W, 16, width of saturating stall/flush counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID holds a real instruction
id_src1  in  REG_ADDR_W  Rn of ID instruction
id_src2  in  REG_ADDR_W  Rm/Rd-for-store of ID instruction
id_two_src  in  1  id_src2 is read
id_wb_en  in  1  ID instruction writes back
id_mem_read  in  1  ID instruction is a load
id_dest  in  REG_ADDR_W  ID destination
branch_taken  in  1  EXE resolved a taken branch (1-cycle pulse)
mem_ready  in  1  data memory can complete this cycle
freeze  out  1  hold PC and IF/ID register
hazard  out  1  to ID_stage: insert bubble
flush  out  1  clear IF/ID register and ID output
stall_cnt  out  CNT_W  saturating count of hazard cycles
flush_cnt  out  CNT_W  saturating count of taken branches

Behaviour:
- Reset (synchronous, rst=1 at posedge): all scoreboard entries invalid, flush counter 0, branch_pending 0, stall_cnt=0, flush_cnt=0. Combinational outputs then evaluate to freeze=0, hazard=0, flush=0.
- Scoreboard entry = {valid, wb_en, mem_read, dest}. Entry 0 = EXE, entry DEPTH-1 = oldest.
- mem_wait = ~mem_ready. While mem_wait: scoreboard holds and counters do not advance. The only exception is that branch_taken still sets branch_pending.
- Otherwise each posedge shifts entry i to entry i+1; entry DEPTH-1 is dropped. Entry 0 loads the ID instruction only if id_valid & ~hazard & ~flush; else entry 0 loads a bubble (valid=0).
- match(s) = any entry with valid & wb_en & dest==s. RAW = id_valid & (match(id_src1) | (id_two_src & match(id_src2))).
- hazard = RAW & ~flush (combinational). flush takes priority: the ID instruction is being discarded.
- freeze = hazard | mem_wait.
- Flush sequencing: when (branch_taken | branch_pending) & ~mem_wait, flush goes high for FLUSH_CYCLES consecutive non-wait cycles via a down-counter; branch_pending clears. A branch_taken arriving during an active flush restarts the counter at FLUSH_CYCLES.
- flush is combinationally high in the branch_taken cycle itself when ~mem_wait, then stays high for the remaining FLUSH_CYCLES-1 cycles.
- stall_cnt increments on every cycle with hazard=1. flush_cnt increments on every accepted branch. Both saturate at all-ones, never wrap.
- Register 0 is not special (ARM R0 is a real register); tag compare is full width.
- rst asserted mid-flush or mid-wait aborts everything; the next cycle behaves as after power-on.

Optional Feature:
FORWARDING_EN. When defined, RAW stalls apply only to load-use: a match counts only for entry 0 with mem_read=1. All other matches are assumed forwarded, so hazard lasts at most 1 cycle per load. When undefined, every scoreboard match stalls (full interlock, as specified above).

Test Plan:
- Reset then ID instr dest=R3 wb_en; next cycle ID reads src1=R3 -> without FORWARDING_EN hazard=1, freeze=1 for exactly DEPTH(3) cycles, then 0; stall_cnt=3.
- Same with FORWARDING_EN, producer is a non-load -> hazard never asserts; producer is a load (id_mem_read=1) -> hazard=1 for exactly 1 cycle.
- id_two_src=0, src2=R3 matches in-flight dest R3 -> no hazard; set id_two_src=1 -> hazard=1.
- branch_taken pulse with FLUSH_CYCLES=2 -> flush=1 in that cycle and the next, then 0; a simultaneous RAW gives hazard=0; flush_cnt=1.
- mem_ready=0 for 4 cycles with branch_taken during cycle 2 -> freeze=1 for all 4, flush=0 throughout; flush=1 the first cycle mem_ready=1; scoreboard contents unchanged across the wait.
- Force 2^CNT_W+5 hazard cycles (CNT_W=4 build) -> stall_cnt holds at 15; rst=1 mid-flush -> next cycle flush=0, counters 0.
